// File: rtl/stage_2_decode_pkg.sv
// Shared pipeline types for the RV32I decode stage.
// Holds the opcode constants, the ALU operation enum, the control bundle handed to execute,
// the bubble constant and small helpers for ALU-op selection and immediate generation.
package stage_2_decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    // mem_funct3 carries funct3 for loads/stores (width/sign) and branches (compare type).
    typedef struct packed {
        alu_op_e    alu_op;
        logic       alu_src_imm;
        logic       use_pc;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_funct3;
        logic       reg_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       illegal;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    // alt selects SUB/SRA; callers pass it only where funct7[5] is meaningful.
    function automatic alu_op_e alu_op_from_funct(logic [2:0] funct3, logic alt);
        alu_op_e op;
        unique case (funct3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] imm_gen(logic [31:0] instr);
        logic [31:0] imm;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm = {instr[31:12], 12'b0};
            OP_JAL:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default:   imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/stage_2_decode_if.sv
// Fetch/write-back/execute-facing bus of the decode stage.
// slave  : the decode stage (consumes instruction/pc/discard/wb_*, drives hazard and results)
// master : the surrounding pipeline (or a bench) driving the stage.
interface stage_2_decode_if #(
    parameter int unsigned XLEN = 32
);
    import stage_2_decode_pkg::*;

    logic [31:0]     instruction_in;
    logic [31:0]     pc_in;
    logic            discard;
    logic            wb_enable;
    logic [4:0]      wb_reg;
    logic [XLEN-1:0] wb_data;
    logic            hazard_stall;
    logic [31:0]     pc_out;
    logic [XLEN-1:0] rs1_value_out;
    logic [XLEN-1:0] rs2_value_out;
    logic [XLEN-1:0] imm_out;
    logic [4:0]      rd_out;
    ctrl_bundle_t    ctrl_out;

    modport master (
        output instruction_in, pc_in, discard, wb_enable, wb_reg, wb_data,
        input  hazard_stall, pc_out, rs1_value_out, rs2_value_out, imm_out, rd_out, ctrl_out
    );

    modport slave (
        input  instruction_in, pc_in, discard, wb_enable, wb_reg, wb_data,
        output hazard_stall, pc_out, rs1_value_out, rs2_value_out, imm_out, rd_out, ctrl_out
    );
endinterface

// File: rtl/stage_2_decode_register_file.sv
// Architectural register file: two combinational read ports, one write port.
// clk/reset     : clock, asynchronous active-high reset (clears every entry)
// we_i/waddr_i/wdata_i : write strobe, index, data (writes to x0 dropped)
// raddr1_i/raddr2_i -> rdata1_o/rdata2_o : reads; x0 reads 0, optional same-cycle bypass
module stage_2_decode_register_file #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_COUNT = 32,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);
    logic [XLEN-1:0] mem_q [REG_COUNT];
    logic [XLEN-1:0] mem_d [REG_COUNT];

    always_comb begin
        mem_d = mem_q;
        if (we_i && (waddr_i != '0)) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Bypass makes a write-back visible to the instruction decoding in the same cycle.
    assign rdata1_o = (raddr1_i == '0) ? '0 :
                      (WB_BYPASS && we_i && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 :
                      (WB_BYPASS && we_i && (waddr_i == raddr2_i)) ? wdata_i : mem_q[raddr2_i];

endmodule

// File: rtl/stage_2_decode.sv
// RV32I decode stage: decodes instruction_in, reads the register file, builds the immediate
// and control bundle, and registers them for execute. Raises hazard_stall on a load-use hazard.
// clk, reset : clock, asynchronous active-high reset (output register and regfile cleared)
// bus        : stage_2_decode_if.slave (fetch inputs, discard, wb_* write port, results)
module stage_2_decode
    import stage_2_decode_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_COUNT = 32,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    stage_2_decode_if.slave  bus
);
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign instr  = bus.instruction_in;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    logic [XLEN-1:0] rdata1, rdata2;

    stage_2_decode_register_file #(
        .XLEN      (XLEN),
        .REG_COUNT (REG_COUNT),
        .WB_BYPASS (WB_BYPASS)
    ) u_register_file (
        .clk      (clk),
        .reset    (reset),
        .we_i     (bus.wb_enable),
        .waddr_i  (bus.wb_reg),
        .wdata_i  (bus.wb_data),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

    ctrl_bundle_t ctrl;
    logic         legal, use_rs1, use_rs2, rd_nz;

    assign rd_nz = (rd != '0);

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_LUI: begin
                legal = 1'b1;
                ctrl.alu_op = AluPassB;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write = rd_nz;
            end
            OP_AUIPC, OP_JAL: begin
                legal = 1'b1;
                ctrl.use_pc = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.jump = (opcode == OP_JAL);
                ctrl.reg_write = rd_nz;
            end
            OP_JALR: begin
                legal = (funct3 == 3'b000);
                use_rs1 = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.jump = 1'b1;
                ctrl.jalr = 1'b1;
                ctrl.reg_write = rd_nz;
            end
            OP_BRANCH: begin
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                ctrl.alu_op = AluSub;
                ctrl.branch = 1'b1;
                ctrl.mem_funct3 = funct3;
            end
            OP_LOAD: begin
                legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                use_rs1 = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.mem_funct3 = funct3;
                ctrl.reg_write = rd_nz;
            end
            OP_STORE: begin
                legal = funct3 inside {3'b000, 3'b001, 3'b010};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.mem_funct3 = funct3;
            end
            OP_IMM: begin
                // Only shifts constrain the upper immediate bits.
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'h00);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                end else begin
                    legal = 1'b1;
                end
                use_rs1 = 1'b1;
                ctrl.alu_op = alu_op_from_funct(funct3, (funct3 == 3'b101) && funct7[5]);
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write = rd_nz;
            end
            OP_REG: begin
                legal = (funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                ctrl.alu_op = alu_op_from_funct(funct3, funct7[5]);
                ctrl.reg_write = rd_nz;
            end
            default: ;
        endcase
        if (!legal) begin
            ctrl = CTRL_BUBBLE;
            ctrl.illegal = 1'b1;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
    end

    logic [31:0]     pc_q, pc_d;
    logic [XLEN-1:0] rs1_value_q, rs1_value_d, rs2_value_q, rs2_value_d, imm_q, imm_d;
    logic [4:0]      rd_q, rd_d;
    ctrl_bundle_t    ctrl_q, ctrl_d;
    logic            load_use;

    // rd_q is already 0 for non-writing ops, so x0 sources can never match.
    assign load_use = ctrl_q.mem_read && (rd_q != '0) &&
                      ((use_rs1 && (rs1 == rd_q)) || (use_rs2 && (rs2 == rd_q)));
    assign bus.hazard_stall = load_use && !bus.discard;

    always_comb begin
        pc_d        = '0;
        rs1_value_d = '0;
        rs2_value_d = '0;
        imm_d       = '0;
        rd_d        = '0;
        ctrl_d      = CTRL_BUBBLE;
        if (!bus.discard && !load_use) begin
            pc_d        = bus.pc_in;
            rs1_value_d = use_rs1 ? rdata1 : '0;
            rs2_value_d = use_rs2 ? rdata2 : '0;
            imm_d       = legal ? XLEN'($signed(imm_gen(instr))) : '0;
            rd_d        = ctrl.reg_write ? rd : '0;
            ctrl_d      = ctrl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= '0;
            rs1_value_q <= '0;
            rs2_value_q <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            ctrl_q      <= CTRL_BUBBLE;
        end else begin
            pc_q        <= pc_d;
            rs1_value_q <= rs1_value_d;
            rs2_value_q <= rs2_value_d;
            imm_q       <= imm_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign bus.pc_out        = pc_q;
    assign bus.rs1_value_out = rs1_value_q;
    assign bus.rs2_value_out = rs2_value_q;
    assign bus.imm_out       = imm_q;
    assign bus.rd_out        = rd_q;
    assign bus.ctrl_out      = ctrl_q;

endmodule

// File: tb/tb_stage_2_decode.sv
// Bench for stage_2_decode: an instruction-level reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_stage_2_decode;
    import stage_2_decode_pkg::*;

    typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ} fmt_e;

    typedef struct packed {
        logic         legal;
        logic         use1;
        logic         use2;
        fmt_e         fmt;
        ctrl_bundle_t ctrl;
    } info_t;

    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  rs1;
        logic [31:0]  rs2;
        logic [31:0]  imm;
        logic [4:0]   rd;
        ctrl_bundle_t ctrl;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    stage_2_decode_if #(.XLEN(32)) bus ();

    stage_2_decode #(.XLEN(32), .REG_COUNT(32), .WB_BYPASS(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    function automatic alu_op_e alu_of(logic [2:0] f3);
        alu_op_e tab [8];
        tab = '{AluAdd, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluOr, AluAnd};
        return tab[f3];
    endfunction

    function automatic info_t model_info(logic [31:0] ins);
        info_t      i;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       wr;
        f3 = ins[14:12];
        f7 = ins[31:25];
        wr = (ins[11:7] != 5'd0);
        i = '0;
        case (ins[6:0])
            OP_REG: begin
                i.fmt = FmtR; i.use1 = 1; i.use2 = 1; i.ctrl.reg_write = wr;
                i.legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                i.ctrl.alu_op = alu_of(f3);
                if (f7 == 7'h20) i.ctrl.alu_op = (f3 == 0) ? AluSub : AluSra;
            end
            OP_IMM: begin
                i.fmt = FmtI; i.use1 = 1; i.ctrl.reg_write = wr; i.ctrl.alu_src_imm = 1;
                i.legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
                i.ctrl.alu_op = alu_of(f3);
                if (f3 == 5 && f7 == 7'h20) i.ctrl.alu_op = AluSra;
            end
            OP_LOAD: begin
                i.fmt = FmtI; i.use1 = 1; i.ctrl.reg_write = wr; i.ctrl.alu_src_imm = 1;
                i.legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                i.ctrl.mem_read = 1; i.ctrl.mem_funct3 = f3;
            end
            OP_STORE: begin
                i.fmt = FmtS; i.use1 = 1; i.use2 = 1; i.ctrl.alu_src_imm = 1;
                i.legal = (f3 < 3); i.ctrl.mem_write = 1; i.ctrl.mem_funct3 = f3;
            end
            OP_BRANCH: begin
                i.fmt = FmtB; i.use1 = 1; i.use2 = 1; i.legal = (f3 != 2 && f3 != 3);
                i.ctrl.alu_op = AluSub; i.ctrl.branch = 1; i.ctrl.mem_funct3 = f3;
            end
            OP_JAL: begin
                i.fmt = FmtJ; i.legal = 1; i.ctrl.use_pc = 1; i.ctrl.alu_src_imm = 1;
                i.ctrl.jump = 1; i.ctrl.reg_write = wr;
            end
            OP_JALR: begin
                i.fmt = FmtI; i.use1 = 1; i.legal = (f3 == 0); i.ctrl.alu_src_imm = 1;
                i.ctrl.jump = 1; i.ctrl.jalr = 1; i.ctrl.reg_write = wr;
            end
            OP_LUI: begin
                i.fmt = FmtU; i.legal = 1; i.ctrl.alu_op = AluPassB;
                i.ctrl.alu_src_imm = 1; i.ctrl.reg_write = wr;
            end
            OP_AUIPC: begin
                i.fmt = FmtU; i.legal = 1; i.ctrl.use_pc = 1;
                i.ctrl.alu_src_imm = 1; i.ctrl.reg_write = wr;
            end
            default: i.legal = 0;
        endcase
        return i;
    endfunction

    function automatic logic [31:0] model_imm(logic [31:0] ins, fmt_e fmt);
        case (fmt)
            FmtI: return 32'($signed(ins[31:20]));
            FmtS: return 32'($signed({ins[31:25], ins[11:7]}));
            FmtB: return 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) << 1;
            FmtU: return ins & 32'hFFFF_F000;
            FmtJ: return 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) << 1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t model_decode(logic [31:0] ins, logic [31:0] pc,
                                          logic [31:0] v1, logic [31:0] v2);
        exp_t  e;
        info_t inf;
        inf = model_info(ins);
        e = '0;
        e.pc = pc;
        if (!inf.legal) begin
            e.ctrl.illegal = 1'b1;
            return e;
        end
        e.ctrl = inf.ctrl;
        e.imm  = model_imm(ins, inf.fmt);
        e.rs1  = inf.use1 ? v1 : 32'd0;
        e.rs2  = inf.use2 ? v2 : 32'd0;
        e.rd   = inf.ctrl.reg_write ? ins[11:7] : 5'd0;
        return e;
    endfunction

    function automatic logic model_hazard(logic mem_read, logic [4:0] rd, logic [31:0] ins,
                                          logic disc);
        info_t inf;
        inf = model_info(ins);
        if (disc || !mem_read || rd == 0 || !inf.legal) return 1'b0;
        return (inf.use1 && ins[19:15] == rd) || (inf.use2 && ins[24:20] == rd);
    endfunction

    logic [31:0] mregs [32];
    exp_t        exp_q;

    function automatic logic [31:0] mread(logic [4:0] r);
        if (r == 0) return 32'd0;
        if (bus.wb_enable && bus.wb_reg == r) return bus.wb_data;
        return mregs[r];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q <= '0;
            for (int r = 0; r < 32; r++) mregs[r] <= 32'd0;
        end else begin
            if (model_hazard(exp_q.ctrl.mem_read, exp_q.rd, bus.instruction_in, bus.discard))
                exp_q <= '0;
            else if (bus.discard)
                exp_q <= '0;
            else
                exp_q <= model_decode(bus.instruction_in, bus.pc_in,
                                      mread(bus.instruction_in[19:15]),
                                      mread(bus.instruction_in[24:20]));
            if (bus.wb_enable && bus.wb_reg != 0) mregs[bus.wb_reg] <= bus.wb_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    // Every cycle, away from the rising edge.
    always @(negedge clk) begin
        chk("m_pc", bus.pc_out, exp_q.pc);
        chk("m_rs1", bus.rs1_value_out, exp_q.rs1);
        chk("m_rs2", bus.rs2_value_out, exp_q.rs2);
        chk("m_imm", bus.imm_out, exp_q.imm);
        chk("m_rd", 32'(bus.rd_out), 32'(exp_q.rd));
        chk("m_ctrl", 32'(bus.ctrl_out), 32'(exp_q.ctrl));
        chk("m_hazard", 32'(bus.hazard_stall),
            32'(model_hazard(exp_q.ctrl.mem_read, exp_q.rd, bus.instruction_in, bus.discard)));
    end

    // ---------------- stimulus ----------------
    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_REG};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        bus.instruction_in = ins;
        bus.pc_in = pc;
    endtask

    task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        bus.wb_enable = en;
        bus.wb_reg = r;
        bus.wb_data = d;
    endtask

    logic [31:0] misc [12];

    initial begin
        drive(NOP, 32'd0);
        bus.discard = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        #1 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        wb(1'b1, 5'd1, 32'h0000_0100);
        tick();
        wb(1'b1, 5'd2, 32'h0000_0022);
        tick();

        // Same-cycle write-back bypass.
        wb(1'b1, 5'd5, 32'h0000_1234);
        drive(enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd6), 32'h0000_000C);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        chk("bypass_rs1", bus.rs1_value_out, 32'h0000_1234);
        chk("bypass_rd", 32'(bus.rd_out), 32'd6);

        // Load-use: one stall cycle, one bubble, then the add issues.
        drive(enc_i(12'd0, 5'd1, 3'b010, 5'd7, OP_LOAD), 32'h0000_0010);
        tick();
        drive(enc_r(7'h00, 5'd2, 5'd7, 3'b000, 5'd8), 32'h0000_0014);
        #1 chk("lu_stall", 32'(bus.hazard_stall), 32'd1);
        tick();
        chk("lu_bubble_rd", 32'(bus.rd_out), 32'd0);
        chk("lu_bubble_ctrl", 32'(bus.ctrl_out), 32'd0);
        chk("lu_stall_clear", 32'(bus.hazard_stall), 32'd0);
        tick();
        chk("lu_issue_rd", 32'(bus.rd_out), 32'd8);
        chk("lu_issue_pc", bus.pc_out, 32'h0000_0014);
        chk("lu_issue_rs2", bus.rs2_value_out, 32'h0000_0022);

        // lui after lw does not read registers.
        drive(enc_i(12'd0, 5'd1, 3'b010, 5'd7, OP_LOAD), 32'h0000_0018);
        tick();
        drive({20'h12345, 5'd7, OP_LUI}, 32'h0000_001C);
        #1 chk("lui_no_stall", 32'(bus.hazard_stall), 32'd0);
        tick();

        // Discard of a branch, then discard overriding a load-use stall.
        drive(enc_b(13'd8, 5'd2, 5'd1, 3'b000), 32'h0000_0020);
        bus.discard = 1'b1;
        tick();
        bus.discard = 1'b0;
        chk("disc_ctrl", 32'(bus.ctrl_out), 32'd0);
        chk("disc_rd", 32'(bus.rd_out), 32'd0);
        tick();
        chk("beq_imm", bus.imm_out, 32'h0000_0008);
        drive(enc_i(12'd0, 5'd1, 3'b010, 5'd7, OP_LOAD), 32'h0000_0024);
        tick();
        drive(enc_r(7'h00, 5'd2, 5'd7, 3'b000, 5'd8), 32'h0000_0028);
        bus.discard = 1'b1;
        #1 chk("disc_beats_stall", 32'(bus.hazard_stall), 32'd0);
        tick();
        bus.discard = 1'b0;

        // Immediates.
        drive(enc_s(12'hFFC, 5'd2, 5'd1, 3'b010), 32'h0000_002C);
        tick();
        chk("sw_imm", bus.imm_out, 32'hFFFF_FFFC);
        chk("sw_rs2", bus.rs2_value_out, 32'h0000_0022);
        drive(32'h0010_00EF, 32'h0000_0030);
        tick();
        chk("jal_imm", bus.imm_out, 32'h0000_0800);
        drive(32'hABCD_E197, 32'h0000_0034);
        tick();
        chk("auipc_imm", bus.imm_out, 32'hABCD_E000);

        // Illegal instruction, then a write-back aimed at x0.
        drive(32'hFFFF_FFFF, 32'h0000_0040);
        tick();
        chk("ill_flag", 32'(bus.ctrl_out.illegal), 32'd1);
        chk("ill_regwrite", 32'(bus.ctrl_out.reg_write), 32'd0);
        chk("ill_pc", bus.pc_out, 32'h0000_0040);
        wb(1'b1, 5'd0, 32'hDEAD_BEEF);
        drive(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd9), 32'h0000_0044);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        chk("x0_bypass", bus.rs1_value_out, 32'd0);
        tick();
        chk("x0_after", bus.rs1_value_out, 32'd0);

        // Mixed decode coverage, checked by the model.
        misc = '{enc_i(12'hFFF, 5'd1, 3'b000, 5'd3, OP_IMM),
                 enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4),
                 enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd4),
                 enc_i(12'h403, 5'd1, 3'b101, 5'd4, OP_IMM),
                 enc_i(12'h805, 5'd2, 3'b010, 5'd10, OP_IMM),
                 enc_i(12'h010, 5'd1, 3'b100, 5'd11, OP_LOAD),
                 enc_s(12'h7F0, 5'd3, 5'd1, 3'b001),
                 enc_b(13'h1FF0, 5'd4, 5'd3, 3'b001),
                 enc_i(12'h004, 5'd2, 3'b000, 5'd1, OP_JALR),
                 enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd12),
                 enc_i(12'h004, 5'd2, 3'b001, 5'd1, OP_JALR),
                 enc_r(7'h00, 5'd3, 5'd4, 3'b011, 5'd13)};
        foreach (misc[k]) begin
            drive(misc[k], 32'h0000_0100 + 32'(k) * 4);
            tick();
        end

        // Reset while stalled.
        drive(enc_i(12'd0, 5'd1, 3'b010, 5'd7, OP_LOAD), 32'h0000_0200);
        tick();
        drive(enc_r(7'h00, 5'd2, 5'd7, 3'b000, 5'd8), 32'h0000_0204);
        #1 chk("pre_reset_stall", 32'(bus.hazard_stall), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_stall", 32'(bus.hazard_stall), 32'd0);
        chk("rst_pc", bus.pc_out, 32'd0);
        chk("rst_ctrl", 32'(bus.ctrl_out), 32'd0);
        chk("rst_rs2", bus.rs2_value_out, 32'd0);
        tick();
        reset = 1'b0;
        for (int r = 1; r < 32; r++) begin
            drive(enc_r(7'h00, 5'(r), 5'(r), 3'b000, 5'd9), 32'h0000_0300);
            tick();
            chk("rst_reg_zero", bus.rs1_value_out, 32'd0);
        end
        drive(NOP, 32'd0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
